// File: rtl/wbc_rr_intercon.sv
// Shared WISHBONE interconnect: NUM_M masters share one bus to NUM_S slaves with a round-robin owner and base/mask decode.
// Latency: grant is registered one cycle after cyc. Request and response paths are combinational. Internal err pulses are registered one cycle.
// Backpressure: non-owners wait with cyc held. The owner keeps the bus until it drops cyc, and each handover costs one dead cycle.
//
// Ports:
//   clk_i, rst_n_i                      bus clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i              per-master strobes
//   m_adr_i/m_dat_i/m_sel_i             packed per-master address / write data / byte selects
//   m_ack_o/m_err_o/m_rty_o             per-master responses (only the owner ever sees them)
//   m_dat_o                             read data, broadcast to all masters
//   s_cyc_o/s_stb_o/s_we_o              per-slave strobes (owner strobes gated by decode hit)
//   s_adr_o/s_dat_o/s_sel_o             owner offset (address AND hit slave mask), write data, selects
//   s_ack_i/s_err_i/s_rty_i/s_dat_i     per-slave responses and packed read data
//   gnt_o                               one-hot current owner, all-zero when idle
//   debug_o                             registered snapshot when WBC_RR_INTERCON_DEBUG_EN is defined, else 0
module wbc_rr_intercon #(
    parameter  int                     NUM_M   = 4,
    parameter  int                     NUM_S   = 4,
    parameter  int                     ADR_W   = 20,
    parameter  int                     DAT_W   = 32,
    parameter  logic [NUM_S*ADR_W-1:0] S_BASE  = '0,
    parameter  logic [NUM_S*ADR_W-1:0] S_MASK  = '0,
    parameter  int                     TIMEOUT = 255,
    localparam int                     SEL_W   = DAT_W / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_M-1:0]         m_cyc_i,
    input  logic [NUM_M-1:0]         m_stb_i,
    input  logic [NUM_M-1:0]         m_we_i,
    input  logic [NUM_M*ADR_W-1:0]   m_adr_i,
    input  logic [NUM_M*DAT_W-1:0]   m_dat_i,
    input  logic [NUM_M*SEL_W-1:0]   m_sel_i,
    output logic [NUM_M-1:0]         m_ack_o,
    output logic [NUM_M-1:0]         m_err_o,
    output logic [NUM_M-1:0]         m_rty_o,
    output logic [DAT_W-1:0]         m_dat_o,
    output logic [NUM_S-1:0]         s_cyc_o,
    output logic [NUM_S-1:0]         s_stb_o,
    output logic [NUM_S-1:0]         s_we_o,
    output logic [ADR_W-1:0]         s_adr_o,
    output logic [DAT_W-1:0]         s_dat_o,
    output logic [SEL_W-1:0]         s_sel_o,
    input  logic [NUM_S-1:0]         s_ack_i,
    input  logic [NUM_S-1:0]         s_err_i,
    input  logic [NUM_S-1:0]         s_rty_i,
    input  logic [NUM_S*DAT_W-1:0]   s_dat_i,
    output logic [NUM_M-1:0]         gnt_o,
    output logic [79:0]              debug_o
);

    localparam int          MI_W    = $clog2(NUM_M);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q;
    logic [NUM_M-1:0]   gnt_q;
    logic [MI_W-1:0]    last_q;
    logic [MI_W-1:0]    pick_idx;
    logic [MI_W-1:0]    cand;
    logic               pick_vld;

    logic               own_vld, own_cyc, own_stb, own_we;
    logic [ADR_W-1:0]   own_adr;
    logic [DAT_W-1:0]   own_dat;
    logic [SEL_W-1:0]   own_sel;

    logic [NUM_S-1:0]   hit_oh;
    logic               hit_any;
    logic [ADR_W-1:0]   hit_mask;

    logic               sl_ack, sl_err, sl_rty, sl_resp;
    logic [DAT_W-1:0]   sl_dat;

    logic               dec_err_q, to_err_q, int_err;
    logic [15:0]        to_cnt_q;

    // Round-robin search starting just after the last owner. The loop runs
    // from the farthest offset down so the nearest requester is assigned last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = NUM_M; off >= 1; off--) begin
            cand = MI_W'((int'(last_q) + off) % NUM_M);
            if (m_cyc_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Arbiter: the grant is registered and held for the owner's whole cycle.
    // Releasing always passes through IDLE, so every handover has one dead cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= MI_W'(NUM_M - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= OWN;
                        gnt_q   <= NUM_M'(1) << pick_idx;
                        last_q  <= pick_idx;
                    end
                end
                OWN: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Owner request mux. Every field is zero while nobody holds the grant.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_q[i]) begin
                own_cyc = m_cyc_i[i];
                own_stb = m_cyc_i[i] & m_stb_i[i];
                own_we  = m_cyc_i[i] & m_we_i[i];
                own_adr = m_adr_i[i*ADR_W +: ADR_W];
                own_dat = m_dat_i[i*DAT_W +: DAT_W];
                own_sel = m_sel_i[i*SEL_W +: SEL_W];
            end
        end
    end

    assign own_vld = |gnt_q;

    // Decode. The loop runs from the highest slave index down, so the lowest
    // matching slave is written last and wins when regions overlap.
    always_comb begin
        hit_oh   = '0;
        hit_mask = '0;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            if ((own_adr & ~S_MASK[k*ADR_W +: ADR_W]) == S_BASE[k*ADR_W +: ADR_W]) begin
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
                hit_mask  = S_MASK[k*ADR_W +: ADR_W];
            end
        end
    end

    assign hit_any = |hit_oh;

    // Response mux from the hit slave.
    always_comb begin
        sl_ack = 1'b0;
        sl_err = 1'b0;
        sl_rty = 1'b0;
        sl_dat = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (own_vld && hit_oh[k]) begin
                sl_ack = s_ack_i[k];
                sl_err = s_err_i[k];
                sl_rty = s_rty_i[k];
                sl_dat = s_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

    assign sl_resp = sl_ack | sl_err | sl_rty;

    // Unmapped strobe: err during the following cycle only. If the master
    // still holds stb, the self-clear makes sure the pulse is a single cycle.
    // Hung slave: count stalled strobe cycles to the hit slave. Counting only
    // on a hit keeps unmapped accesses on the decode-err path alone. A grant
    // change always goes through IDLE, where stb is low, so that clears the
    // counter as well.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            dec_err_q <= own_stb & ~hit_any & ~dec_err_q;
            if (!own_stb || !hit_any || sl_resp) begin
                to_cnt_q <= '0;
                to_err_q <= 1'b0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_q <= '0;
                to_err_q <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 16'd1;
                to_err_q <= 1'b0;
            end
        end
    end

    // If a real slave response lands in the same cycle, it takes precedence
    // over an internally generated err.
    assign int_err = (dec_err_q | to_err_q) & ~sl_resp;

    assign s_cyc_o = hit_oh & {NUM_S{own_cyc}};
    assign s_stb_o = hit_oh & {NUM_S{own_stb}};
    assign s_we_o  = hit_oh & {NUM_S{own_we}};
    assign s_adr_o = own_adr & hit_mask;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;

    assign m_ack_o = gnt_q & {NUM_M{sl_ack}};
    assign m_err_o = gnt_q & {NUM_M{sl_err | int_err}};
    assign m_rty_o = gnt_q & {NUM_M{sl_rty}};
    assign m_dat_o = sl_dat;
    assign gnt_o   = gnt_q;

`ifdef WBC_RR_INTERCON_DEBUG_EN
    logic [79:0]      debug_q;
    logic [DAT_W-1:0] dbg_dat;

    assign dbg_dat = own_we ? own_dat : m_dat_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            debug_q <= '0;
        end else begin
            debug_q <= {8'h00, dec_err_q, to_err_q, 8'(gnt_q),
                        |m_rty_o, |m_err_o, |m_ack_o, own_we, own_stb, own_cyc,
                        4'(own_sel), 20'(own_adr), 32'(dbg_dat)};
        end
    end

    assign debug_o = debug_q;
`else
    assign debug_o = 80'h0;
`endif

endmodule
